// File: rtl/bch_encoder_15_7.sv
// ---------------------------------------------------------------------------
// bch_encoder_15_7
//
// Purpose:
//   Systematic BCH(15,7) double-error-correcting encoder over GF(2^4). This is
//   the transmit-side partner of the BM/Chien decoder. A 7-bit message is
//   accepted on a valid/ready handshake. The 8 parity bits are produced by a
//   serial LFSR that takes one message bit per clock, MSB first. The finished
//   codeword is then held on a valid/ready output until it is accepted.
//
// Optional feature (macro BCH_ENC_EXT_PARITY_EN):
//   When the macro is defined, out_cw is 16 bits wide and out_cw[15] is the
//   overall parity of out_cw[14:0]. This gives an extended BCH(16,7) code.
//   When the macro is undefined, out_cw is 15 bits wide and no parity logic
//   is built.
//
// Ports:
//   clk        in   1     single clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     msg_i carries a message
//   in_ready   out  1     encoder is idle and can take a message
//   msg_i      in   7     message, msg_i[6] = coefficient of x^14
//   out_valid  out  1     out_cw holds a complete codeword
//   out_ready  in   1     downstream accepts out_cw
//   out_cw     out  CW_W  codeword {message, remainder} (+ parity if extended)
// ---------------------------------------------------------------------------
module bch_encoder_15_7 #(
  parameter int         N        = 15,
  parameter int         K        = 7,
  parameter logic [8:0] GEN_POLY = 9'h1D1,
`ifdef BCH_ENC_EXT_PARITY_EN
  localparam int        CW_W     = 16
`else
  localparam int        CW_W     = 15
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      msg_i,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [CW_W-1:0] out_cw
);

  // The datapath is sized for exactly this code. Reject any other geometry
  // at elaboration time.
  generate
    if (N != 15 || K != 7 || GEN_POLY[8] != 1'b1) begin : g_bad_params
      $error("bch_encoder_15_7: only N=15, K=7 with a monic degree-8 generator is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    OUT   = 2'd2
  } state_t;

  state_t            state_reg;
  logic [7:0]        r_reg;        // LFSR remainder
  logic [6:0]        msg_sr_reg;   // message bits still to be fed, MSB first
  logic [6:0]        msg_reg;      // untouched copy for the systematic part
  logic [2:0]        cnt_reg;      // message bits consumed so far
  logic              out_valid_reg;
  logic [CW_W-1:0]   out_cw_reg;

  logic              fb;
  logic [7:0]        r_next;
  logic [CW_W-1:0]   cw_next;

  // Division LFSR: the feedback term combines the incoming bit with the
  // outgoing x^7 term. This computes msg(x)*x^8 mod g(x) without a separate
  // flush phase.
  always_comb begin
    fb     = msg_sr_reg[6] ^ r_reg[7];
    r_next = {r_reg[6:0], 1'b0} ^ (fb ? GEN_POLY[7:0] : 8'h00);
  end

`ifdef BCH_ENC_EXT_PARITY_EN
  // The parity bit is formed from the same next-state remainder, so the
  // extension is registered on the same edge as the base codeword.
  assign cw_next = {^{msg_reg, r_next}, msg_reg, r_next};
`else
  assign cw_next = {msg_reg, r_next};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      r_reg         <= 8'h00;
      msg_sr_reg    <= 7'h00;
      msg_reg       <= 7'h00;
      cnt_reg       <= 3'd0;
      out_valid_reg <= 1'b0;
      out_cw_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            msg_reg    <= msg_i;
            msg_sr_reg <= msg_i;
            r_reg      <= 8'h00;
            cnt_reg    <= 3'd0;
            state_reg  <= SHIFT;
          end
        end
        SHIFT: begin
          r_reg      <= r_next;
          msg_sr_reg <= {msg_sr_reg[5:0], 1'b0};
          cnt_reg    <= cnt_reg + 3'd1;
          if (cnt_reg == 3'd6) begin
            // The last message bit is being absorbed on this edge, so r_next
            // already holds the final remainder.
            out_cw_reg    <= cw_next;
            out_valid_reg <= 1'b1;
            state_reg     <= OUT;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_cw    = out_cw_reg;

endmodule

// File: tb/tb_bch_encoder_15_7.sv
// ---------------------------------------------------------------------------
// tb_bch_encoder_15_7
//
// Self-checking bench for bch_encoder_15_7. Expected codewords come from
// polynomial long division of msg(x)*x^8 by g(x). Each codeword is also
// checked for zero syndromes S1 and S3 over GF(16), using p(x)=x^4+x+1.
// ---------------------------------------------------------------------------
module tb_bch_encoder_15_7;

`ifdef BCH_ENC_EXT_PARITY_EN
  localparam int CW_W = 16;
`else
  localparam int CW_W = 15;
`endif

  logic            clk;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      msg_i;
  logic            out_valid;
  logic            out_ready;
  logic [CW_W-1:0] out_cw;

  int checks = 0;
  int errors = 0;

  bch_encoder_15_7 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .msg_i     (msg_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cw    (out_cw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: long division of msg(x)*x^8 by g(x)=0x1D1.
  function automatic logic [14:0] bch_ref(input logic [6:0] m);
    logic [14:0] d;
    d = {m, 8'h00};
    for (int i = 14; i >= 8; i--)
      if (d[i]) d = d ^ (15'h01D1 << (i - 8));
    return {m, d[7:0]};
  endfunction

  function automatic logic [CW_W-1:0] full_cw(input logic [14:0] c);
`ifdef BCH_ENC_EXT_PARITY_EN
    return {^c, c};
`else
    return c;
`endif
  endfunction

  function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] x;
    p = 4'h0;
    x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction

  // S_j = c(alpha^j).
  function automatic logic [3:0] syndrome(input logic [14:0] c, input int j);
    logic [3:0] step;
    logic [3:0] pw;
    logic [3:0] s;
    step = 4'h1;
    for (int i = 0; i < j; i++) step = gf_mul(step, 4'h2);
    pw = 4'h1;
    s  = 4'h0;
    for (int i = 0; i < 15; i++) begin
      if (c[i]) s = s ^ pw;
      pw = gf_mul(pw, step);
    end
    return s;
  endfunction

  // Send one message and check latency, codeword, syndromes and handshake.
  // If hold > 0, out_ready is held low for hold cycles. During that time the
  // source also presents a competing in_valid, which must be ignored.
  task automatic do_msg(input string tag, input logic [6:0] m,
                        input logic [14:0] exp15, input int hold);
    int n;
    logic [CW_W-1:0] held;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({tag, "_rdy"}, {31'd0, in_ready}, 32'd1);
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    msg_i     = m;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    msg_i     = 7'($urandom);
    n = 0;
    while (!out_valid && n < 20) begin
      check({tag, "_busy_rdy"}, {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1; n++;
    end
    check({tag, "_lat"}, 32'(n), 32'd7);
    check({tag, "_cw"}, 32'(out_cw), 32'(full_cw(exp15)));
    check({tag, "_s1"}, 32'(syndrome(out_cw[14:0], 1)), 32'd0);
    check({tag, "_s3"}, 32'(syndrome(out_cw[14:0], 3)), 32'd0);
    if (hold > 0) begin
      held = out_cw;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        msg_i    = 7'($urandom);
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_cw !== held || in_ready !== 1'b0)
          check({tag, "_hold"}, {out_valid, in_ready, 30'(out_cw)},
                {1'b1, 1'b0, 30'(held)});
      end
      check({tag, "_hold_cw"}, 32'(out_cw), 32'(held));
      check({tag, "_hold_v"}, {31'd0, out_valid}, 32'd1);
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check({tag, "_done_v"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_done_rdy"}, {31'd0, in_ready}, 32'd1);
    $display("msg 0x%02h cw 0x%04h hold %0d", m, out_cw, hold);
  endtask

  initial begin
    logic [6:0] m;
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    msg_i     = 7'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    check("rst_v", {31'd0, out_valid}, 32'd0);
    check("rst_cw", 32'(out_cw), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vectors.
    do_msg("m00", 7'h00, 15'h0000, 0);
    do_msg("m01", 7'h01, 15'h01D1, 0);
    do_msg("m40", 7'h40, 15'h40E8, 0);
    do_msg("m7f", 7'h7F, 15'h7FFF, 0);

    // Backpressure.
    do_msg("bp", 7'h55, bch_ref(7'h55), 20);

    // Reset in the middle of SHIFT, once cnt has reached 3.
    in_valid = 1'b1;
    msg_i    = 7'h2A;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_rdy", {31'd0, in_ready}, 32'd1);
    check("mrst_cw", 32'(out_cw), 32'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("mrst_nov", 32'(seen), 32'd0);
    do_msg("after_rst", 7'h01, 15'h01D1, 0);

    // Random back-to-back traffic.
    for (int i = 0; i < 24; i++) begin
      m = 7'($urandom);
      do_msg("rnd", m, bch_ref(m), (i % 8 == 7) ? int'($urandom_range(1, 5)) : 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
